// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce / edge-detect conditioning stage.
// State encoding, the FSM state type and the counter width helper.
package debounce_pkg;

    localparam logic [1:0] ST_STABLE_LO = 2'd0;
    localparam logic [1:0] ST_WAIT_HI   = 2'd1;
    localparam logic [1:0] ST_STABLE_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO   = 2'd3;

    typedef enum logic [1:0] {
        STABLE_LO = ST_STABLE_LO,
        WAIT_HI   = ST_WAIT_HI,
        STABLE_HI = ST_STABLE_HI,
        WAIT_LO   = ST_WAIT_LO
    } state_e;

    // Counter must hold 0..stable_cycles without wrapping.
    function automatic int cnt_w(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// Reset loads both flops with RESET_LEVEL so no false edge appears at release.
module sync_2ff
    import debounce_pkg::*;
#(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic sync1_q;
    logic sync2_q;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
        end
    end

    assign q = sync2_q;

endmodule

// File: rtl/debounce_edge_detect.sv
// Synchronise, debounce and edge-detect a bouncy asynchronous input.
// Optional fall-edge output is built when DEBOUNCE_FALL_EN is defined.
module debounce_edge_detect
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = 4,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
`ifdef DEBOUNCE_FALL_EN
    ,
    output logic fall
`endif
);

    localparam int CNT_W = cnt_w(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam state_e RST_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    logic             sync2;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;

    sync_2ff #(
        .RESET_LEVEL(RESET_LEVEL)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (din),
        .q    (sync2)
    );

    // A new level is accepted only after STABLE_CYCLES matching samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        unique case (state_q)
            STABLE_LO: begin
                if (sync2) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = STABLE_HI;
                        level_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_HI: begin
                if (!sync2) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    level_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!sync2) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = STABLE_LO;
                        level_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_LO: begin
                if (sync2) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    level_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RST_STATE;
                cnt_d   = '0;
            end
        endcase
    end

    // Edges are exactly the cycles where the accepted level changes.
    assign rise_d = ~level_q & level_d;

    // FSM, counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

`ifdef DEBOUNCE_FALL_EN
    logic fall_q;
    logic fall_d;

    assign fall_d = level_q & ~level_d;

    // Registered one-cycle pulse on an accepted 1->0 change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= fall_d;
        end
    end

    assign fall = fall_q;
`endif

endmodule
